// File: rtl/led_strip_sequencer.sv
// Animated LED strip pattern sequencer with prescaled stepping,
// a mode-accepted status flag and a pattern-wrap pulse.
module led_strip_sequencer #(
    parameter int WIDTH = 16,
    parameter int DIV   = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [2:0]       MOD,
    output logic [WIDTH-1:0] LEDs_strip,
    output logic             ok,
    output logic             wrap
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    typedef enum logic [2:0] {
        M_OFF, M_RUN_L, M_RUN_R, M_FILL,
        M_BLINK, M_BOUNCE, M_COUNT, M_FREEZE
    } mode_t;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

    mode_t            r_mode, w_mode, w_req;
    dir_t             r_dir, w_dir;
    logic [WIDTH-1:0] r_leds, w_leds;
    logic [PW-1:0]    r_pre, w_pre;
    logic             r_ok, w_ok;
    logic             r_wrap, w_wrap;
    logic             w_step;
    logic             w_full;

    assign w_req  = mode_t'(MOD);
    assign w_step = (r_pre == PMAX);
    assign w_full = (r_leds == ONES);

    always_comb begin
        w_mode = r_mode;
        w_dir  = r_dir;
        w_leds = r_leds;
        w_pre  = r_pre + PW'(1);
        w_ok   = r_ok;
        w_wrap = 1'b0;
        if (w_req != r_mode) begin
            // A new mode restarts timing; a coincident step is dropped.
            w_mode = w_req;
            w_pre  = '0;
            w_dir  = DIR_UP;
            w_ok   = 1'b0;
            unique case (w_req)
                M_OFF:    w_leds = '0;
                M_RUN_L:  w_leds = ONE;
                M_RUN_R:  w_leds = MSB;
                M_FILL:   w_leds = '0;
                M_BLINK:  w_leds = '0;
                M_BOUNCE: w_leds = ONE;
                M_COUNT:  w_leds = '0;
                M_FREEZE: w_leds = r_leds;
            endcase
        end else if (w_step) begin
            w_pre = '0;
            w_ok  = 1'b1;
            unique case (r_mode)
                M_OFF: w_leds = '0;
                M_RUN_L: begin
                    w_leds = {r_leds[WIDTH-2:0], r_leds[WIDTH-1]};
                    w_wrap = r_leds[WIDTH-1];
                end
                M_RUN_R: begin
                    w_leds = {r_leds[0], r_leds[WIDTH-1:1]};
                    w_wrap = r_leds[0];
                end
                M_FILL: begin
                    w_leds = w_full ? '0 : {r_leds[WIDTH-2:0], 1'b1};
                    w_wrap = w_full;
                end
                M_BLINK: begin
                    w_leds = ~r_leds;
                    w_wrap = w_full;
                end
                M_BOUNCE: begin
                    if (r_dir == DIR_UP) begin
                        w_leds = {r_leds[WIDTH-2:0], 1'b0};
                        if (r_leds[WIDTH-2]) w_dir = DIR_DOWN;
                    end else begin
                        w_leds = {1'b0, r_leds[WIDTH-1:1]};
                        if (r_leds[1]) begin
                            w_dir  = DIR_UP;
                            w_wrap = 1'b1;
                        end
                    end
                end
                M_COUNT: begin
                    w_leds = r_leds + ONE;
                    w_wrap = w_full;
                end
                M_FREEZE: w_leds = r_leds;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_mode <= M_OFF;
            r_dir  <= DIR_UP;
            r_leds <= '0;
            r_pre  <= '0;
            r_ok   <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_mode <= w_mode;
            r_dir  <= w_dir;
            r_leds <= w_leds;
            r_pre  <= w_pre;
            r_ok   <= w_ok;
            r_wrap <= w_wrap;
        end
    end

    assign LEDs_strip = r_leds;
    assign ok         = r_ok;
    assign wrap       = r_wrap;

endmodule

// File: tb/tb_led_strip_sequencer.sv
// Scoreboard bench: two sequencer instances share stimulus and are
// checked against a step-index reference model of each pattern.
module tb_led_strip_sequencer;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [2:0]  MOD   = 3'd0;
    logic [15:0] leds_a;
    logic        ok_a, wrap_a;
    logic [3:0]  leds_b;
    logic        ok_b, wrap_b;

    always #5 CLOCK = ~CLOCK;

    led_strip_sequencer #(.WIDTH(16), .DIV(4)) u_a (
        .CLOCK(CLOCK), .RESET(RESET), .MOD(MOD),
        .LEDs_strip(leds_a), .ok(ok_a), .wrap(wrap_a)
    );

    led_strip_sequencer #(.WIDTH(4), .DIV(1)) u_b (
        .CLOCK(CLOCK), .RESET(RESET), .MOD(MOD),
        .LEDs_strip(leds_b), .ok(ok_b), .wrap(wrap_b)
    );

    typedef struct packed {
        logic [15:0] leds;
        logic        ok;
        logic        wrap;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_chk = 0;
    int   n_pass = 0;

    int          m_w[2] = '{16, 4};
    int          m_d[2] = '{4, 1};
    logic [2:0]  m_mode[2];
    int          m_k[2];
    int          m_cyc[2];
    logic [15:0] m_leds[2];
    logic [15:0] m_frz[2];
    logic        m_ok[2];
    logic        m_wrap[2];

    // Pattern after k steps, from the closed-form description of each mode.
    function automatic logic [15:0] pat(int w, logic [2:0] md, int k,
                                        logic [15:0] frz);
        logic [31:0] one;
        int p, per;
        one = 32'd1;
        per = 2 * w - 2;
        case (md)
            3'd0: return 16'd0;
            3'd1: return 16'(one << (k % w));
            3'd2: return 16'(one << (w - 1 - k % w));
            3'd3: return 16'((one << (k % (w + 1))) - 1);
            3'd4: return (k % 2 == 1) ? 16'((one << w) - 1) : 16'd0;
            3'd5: begin
                p = k % per;
                if (p >= w) p = per - p;
                return 16'(one << p);
            end
            3'd6: return 16'(k % (1 << w));
            default: return frz;
        endcase
    endfunction

    function automatic int period(int w, logic [2:0] md);
        case (md)
            3'd1, 3'd2: return w;
            3'd3: return w + 1;
            3'd4: return 2;
            3'd5: return 2 * w - 2;
            3'd6: return 1 << w;
            default: return 0;
        endcase
    endfunction

    task automatic model(int i, logic rst, logic [2:0] md);
        int per;
        if (rst) begin
            m_mode[i] = 3'd0;
            m_k[i] = 0;
            m_cyc[i] = 0;
            m_leds[i] = 16'd0;
            m_ok[i] = 1'b0;
            m_wrap[i] = 1'b0;
        end else if (md != m_mode[i]) begin
            if (md == 3'd7) m_frz[i] = m_leds[i];
            m_mode[i] = md;
            m_k[i] = 0;
            m_cyc[i] = 0;
            m_ok[i] = 1'b0;
            m_wrap[i] = 1'b0;
            m_leds[i] = pat(m_w[i], md, 0, m_frz[i]);
        end else begin
            m_cyc[i]++;
            m_wrap[i] = 1'b0;
            if (m_cyc[i] % m_d[i] == 0) begin
                m_k[i]++;
                m_ok[i] = 1'b1;
                per = period(m_w[i], md);
                m_wrap[i] = (per > 0) && (m_k[i] % per == 0);
                m_leds[i] = pat(m_w[i], md, m_k[i], m_frz[i]);
            end
        end
    endtask

    task automatic drive(logic rst, logic [2:0] md);
        @(negedge CLOCK);
        RESET = rst;
        MOD = md;
        for (int i = 0; i < 2; i++) model(i, rst, md);
        q_a.push_back('{m_leds[0], m_ok[0], m_wrap[0]});
        q_b.push_back('{m_leds[1], m_ok[1], m_wrap[1]});
    endtask

    task automatic hold(logic [2:0] md, int n);
        repeat (n) drive(1'b0, md);
    endtask

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLOCK);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("a_leds", leds_a, e.leds);
                check("a_ok", 16'(ok_a), 16'(e.ok));
                check("a_wrap", 16'(wrap_a), 16'(e.wrap));
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("b_leds", 16'(leds_b), e.leds);
                check("b_ok", 16'(ok_b), 16'(e.ok));
                check("b_wrap", 16'(wrap_b), 16'(e.wrap));
            end
        end
    end

    initial begin : stim
        int r;
        for (int i = 0; i < 2; i++) begin
            m_frz[i] = 16'd0;
            model(i, 1'b1, 3'd0);
        end
        drive(1'b1, 3'd1);
        drive(1'b1, 3'd1);
        hold(3'd1, 70);
        hold(3'd5, 4 * 31);
        hold(3'd3, 4 * 18);
        hold(3'd1, 4);
        hold(3'd4, 12);
        hold(3'd1, 21);
        hold(3'd7, 40);
        hold(3'd0, 8);
        hold(3'd5, 4 * 20);
        drive(1'b1, 3'd5);
        hold(3'd5, 20);
        hold(3'd6, 40);
        for (int s = 0; s < 60; s++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                repeat ($urandom_range(1, 3)) drive(1'b1, 3'($urandom_range(0, 7)));
            end else if (r < 3) begin
                repeat (8) drive(1'b0, 3'($urandom_range(0, 7)));
            end else begin
                hold(3'($urandom_range(0, 7)), $urandom_range(1, 300));
            end
        end
        repeat (3) @(negedge CLOCK);
        check("drain_a", 16'(q_a.size()), 16'd0);
        check("drain_b", 16'(q_b.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
